// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-slot TDM receiver
package tdm_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - wrapping slot counter with one-hot write-enable decode
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  logic           load1,
  input  logic           clr,
  output slot_t          sel,
  output logic [NCH-1:0] we
);

  slot_t sel_q, sel_d;

  // clear beats load beats advance; slot 3 + 1 wraps naturally to 0
  always_comb begin
    sel_d = sel_q;
    if (clr) begin
      sel_d = '0;
    end else if (load1) begin
      sel_d = slot_t'(1);
    end else if (adv) begin
      sel_d = sel_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  always_comb begin
    we        = '0;
    we[sel_q] = 1'b1;
  end

  assign sel = sel_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - framed 4-slot TDM receiver presenting whole frames in parallel
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [1:0]   sel,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic         sync_err,
  output logic         locked
);

  state_t         state_q, state_d;
  logic [W-1:0]   shadow_q [NCH-1];
  logic [W-1:0]   shadow_d [NCH-1];
  logic [W-1:0]   y_q [NCH];
  logic [W-1:0]   y_d [NCH];
  logic           frame_valid_q, frame_valid_d;
  logic           sync_err_q, sync_err_d;
  logic           adv, load1, clr;
  logic [NCH-1:0] we, wr_en;
  slot_t          sel_w;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .load1 (load1),
    .clr   (clr),
    .sel   (sel_w),
    .we    (we)
  );

  // wr_en bit 3 means "frame complete": it loads the outputs instead of a shadow
  always_comb begin
    state_d       = state_q;
    adv           = 1'b0;
    load1         = 1'b0;
    clr           = 1'b0;
    wr_en         = '0;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        wr_en      = {{(NCH-1){1'b0}}, 1'b1};
        load1      = 1'b1;
        state_d    = RUN;
        sync_err_d = (state_q == RUN) && (sel_w != '0);
      end else if (state_q == RUN) begin
        if (sel_w == '0) begin
          sync_err_d = 1'b1;
          clr        = 1'b1;
          state_d    = HUNT;
        end else begin
          wr_en         = we;
          adv           = 1'b1;
          frame_valid_d = we[NCH-1];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH-1; i++) begin
      shadow_d[i] = wr_en[i] ? din : shadow_q[i];
    end
    for (int i = 0; i < NCH; i++) begin
      y_d[i] = y_q[i];
    end
    if (wr_en[NCH-1]) begin
      for (int i = 0; i < NCH-1; i++) begin
        y_d[i] = shadow_q[i];
      end
      y_d[NCH-1] = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < NCH-1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NCH; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      for (int i = 0; i < NCH-1; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      for (int i = 0; i < NCH; i++) begin
        y_q[i] <= y_d[i];
      end
    end
  end

  assign sel         = sel_w;
  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb/tb_tdm_demux_4ch.sv - scoreboard bench for tdm_demux_4ch against a queue-based frame model
module tb_tdm_demux_4ch;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [1:0]   sel;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid, sync_err, locked;

  tdm_demux_4ch #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .sel         (sel),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int             stamp;
    logic [4*W-1:0] words;
  } frame_exp_t;

  frame_exp_t   fq[$];
  int           eq[$];
  logic [W-1:0] part[$];
  bit           m_locked;
  logic [W-1:0] m_y[4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_sel();
    return m_locked ? part.size() : 0;
  endfunction

  // One clock of stimulus; model updated after the edge that consumes it
  task automatic step(bit v, bit s, logic [W-1:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    if (v) begin
      if (s) begin
        if (m_locked && part.size() != 0) eq.push_back(edge_cnt);
        part.delete();
        part.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (part.size() == 0) begin
          eq.push_back(edge_cnt);
          m_locked = 1'b0;
        end else begin
          part.push_back(d);
          if (part.size() == 4) begin
            frame_exp_t f;
            f.stamp = edge_cnt;
            f.words = {part[3], part[2], part[1], part[0]};
            fq.push_back(f);
            for (int i = 0; i < 4; i++) m_y[i] = part[i];
            part.delete();
          end
        end
      end
    end
    chk("sel", 32'(sel), 32'(model_sel()));
    chk("locked", 32'(locked), 32'(m_locked));
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic frame(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [W-1:0] d, int gap);
    logic [W-1:0] w[4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, w[i]);
      if (i < 3) repeat (gap) step(1'b0, 1'b0, W'($urandom));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_y", {y3, y2, y1, y0}, 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(sync_err), 32'h0);
    part.delete();
    m_locked = 1'b0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    fq.delete();
    eq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops expected pulses by edge stamp and checks output stability
  initial begin
    forever begin
      @(negedge clk);
      if (fq.size() != 0 && fq[0].stamp == edge_cnt) begin
        chk("frame_valid", 32'(frame_valid), 32'h1);
        chk("frame_data", {y3, y2, y1, y0}, fq[0].words);
        void'(fq.pop_front());
      end else begin
        chk("no_frame_valid", 32'(frame_valid), 32'h0);
      end
      if (eq.size() != 0 && eq[0] == edge_cnt) begin
        chk("sync_err", 32'(sync_err), 32'h1);
        void'(eq.pop_front());
      end else begin
        chk("no_sync_err", 32'(sync_err), 32'h0);
      end
      chk("y_hold", {y3, y2, y1, y0}, {m_y[3], m_y[2], m_y[1], m_y[0]});
    end
  end

  initial begin
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #2;
    do_reset();

    frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0);
    frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 3);

    step(1, 1, 8'h11); step(1, 0, 8'h22);
    step(1, 1, 8'h33); step(1, 0, 8'h44); step(1, 0, 8'h55); step(1, 0, 8'h66);
    step(0, 0, 8'h00);

    frame(8'h81, 8'h82, 8'h83, 8'h84, 0);
    step(1, 0, 8'h77);
    step(1, 0, 8'h78); step(0, 0, 8'h00); step(1, 0, 8'h79); step(1, 0, 8'h7A);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 1);

    frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 0);
    step(1, 1, 8'h91); step(1, 0, 8'h92);
    do_reset();
    frame(8'hE1, 8'hE2, 8'hE3, 8'hE4, 0);

    for (int f = 0; f < 3; f++) frame(8'(16 * f + 1), 8'(16 * f + 2), 8'(16 * f + 3), 8'(16 * f + 4), 0);

    for (int n = 0; n < 800; n++) begin
      bit v, s;
      v = ($urandom % 4) != 0;
      if (model_sel() == 0) s = ($urandom % 8) != 0;
      else                  s = ($urandom % 12) == 0;
      if ($urandom % 250 == 0) do_reset();
      else step(v, s, W'($urandom));
    end

    repeat (4) step(1'b0, 1'b0, '0);
    chk("frames_drained", 32'(fq.size()), 32'h0);
    chk("errs_drained", 32'(eq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
